uart_rx: RTL and testbench
==========================

# uart_rx

Standalone UART receiver: 8N1 serial-to-parallel, LSB first, mid-bit sampling on a fixed clocks-per-bit divisor. Sits between the FPGA RX pin and the byte consumer, and forms the receive end of the link driven by the UART transmit path. It presents each received byte through a valid/ready handshake and flags framing and overrun errors. Compile-time option adds an even-parity bit.

## Interface
- CLKS_PER_BIT, default 1250, system clocks per bit (12 MHz / 9600 baud); must be ≥ 4
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous reset, active-high
- RX  input  1  serial line, idle high, asynchronous to CLK
- DATA_OUT  output  8  received byte, held stable while DATA_VALID high
- DATA_VALID  output  1  byte available
- DATA_READY  input  1  consumer accepts byte on any CLK edge where DATA_VALID && DATA_READY
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low
- OVERRUN  output  1  one-cycle pulse: byte completed while previous one still unaccepted
- PARITY_ERR  output  1  one-cycle pulse, parity mismatch (tied 0 without UART_RX_PARITY_EN)

## Operation
- RX passes through a 2-flop synchronizer (rx_s); both flops reset to 1.
- Let N = CLKS_PER_BIT, H = N/2 (integer division).
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: on first cycle t0 where rx_s==0, go to START, clear bit counter.
- START: at t0+H sample rx_s; 0 → DATA; 1 → glitch, back to IDLE, no flags.
- DATA: bit i (0..7) sampled at t0+H+(i+1)·N, shifted in LSB first; after bit 7 → PARITY or STOP.
- PARITY: sampled at t0+H+9·N; mismatch against even parity of the 8 data bits recorded.
- STOP: sampled at t0+H+9·N (10·N with parity); then immediately IDLE (mid stop bit), so a following start edge is detectable.
- Stop = 1 and no parity error: byte committed. Stop = 0: FRAME_ERR pulse, byte discarded. Parity error with stop = 1: PARITY_ERR pulse, byte discarded. Both errors: both pulses.
- Commit with DATA_VALID low, or high and accepted same cycle: DATA_OUT loads new byte, DATA_VALID high.
- Commit with DATA_VALID high and not accepted that cycle: OVERRUN pulse, new byte dropped, DATA_OUT/DATA_VALID unchanged.
- Accept without commit: DATA_VALID falls next cycle; DATA_OUT retains last value.
- RST asserted mid-frame: FSM to IDLE immediately, partial byte lost; frame in progress on RX is ignored until line returns idle and a fresh falling edge occurs.

## Timing
- Reset values: DATA_OUT=8'h00, DATA_VALID=0, FRAME_ERR=0, OVERRUN=0, PARITY_ERR=0, FSM=IDLE.
- Synchronizer latency 2 cycles: RX falling edge at pin → t0 two edges later.
- DATA_VALID / error pulses assert on the cycle after the stop-bit sample (t0+H+9·N+1; +N with parity).
- All error flags exactly one cycle wide; DATA_VALID level held until accepted.
- Back-to-back frames with zero idle between stop and next start received without loss.

## Configuration
- UART_RX_PARITY_EN defined: frame is start + 8 data + even parity + stop; PARITY state active; PARITY_ERR live.
- Undefined: 8N1 frame; PARITY state not built; PARITY_ERR constant 0.

## Test plan
- CLKS_PER_BIT=16, DATA_READY=1, send 0xEE 8N1 → DATA_OUT=0xEE, DATA_VALID one cycle high at t0+8+144+1, no error flags.
- Send 0x55 then 0xA3 back-to-back, DATA_READY=0 throughout → DATA_OUT=0x55 held, OVERRUN single pulse at end of second frame, DATA_VALID stays high.
- Send 0x3C with stop bit forced low → FRAME_ERR pulse, DATA_VALID stays 0, DATA_OUT unchanged.
- 4-cycle low glitch on RX from idle → no DATA_VALID, no flags, FSM back to IDLE by t0+9.
- Assert RST during bit 4 of a frame, release, send 0x81 → only 0x81 reported, no flags.
- With UART_RX_PARITY_EN: 0x07 with parity=1 → DATA_OUT=0x07 valid; 0x07 with parity=0 → PARITY_ERR pulse, no DATA_VALID.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    input  logic       DATA_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       PARITY_ERR
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic          rx_meta, rx_s;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          armed_q, armed_d;
    logic          stop_sample;
    logic          commit;
`ifdef UART_RX_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // After reset the receiver only arms once the line has been high for a full bit,
    // so a frame interrupted by reset cannot be picked up half-way through.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        stop_sample = 1'b0;
        commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!armed_q) begin
                    if (!rx_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == BIT_M1) begin
                        armed_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d     = '0;
                    par_err_d = rx_s != (^shift_q);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
`ifdef UART_RX_PARITY_EN
                    commit      = rx_s && !par_err_q;
`else
                    commit      = rx_s;
`endif
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_OUT   <= 8'h00;
            DATA_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            FRAME_ERR <= stop_sample && !rx_s;
            OVERRUN   <= commit && DATA_VALID && !DATA_READY;
            if (commit && (!DATA_VALID || DATA_READY)) begin
                DATA_OUT   <= shift_q;
                DATA_VALID <= 1'b1;
            end else if (DATA_VALID && DATA_READY) begin
                DATA_VALID <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_err_q  <= 1'b0;
            PARITY_ERR <= 1'b0;
        end else begin
            par_err_q  <= par_err_d;
            PARITY_ERR <= stop_sample && par_err_q;
        end
    end
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame-level model predicts each output event and its cycle.
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, parity_err;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .CLK(clk), .RST(rst), .RX(rx),
        .DATA_OUT(data_out), .DATA_VALID(data_valid), .DATA_READY(ready),
        .FRAME_ERR(frame_err), .OVERRUN(overrun), .PARITY_ERR(parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind bits: [3] new byte, [2] frame error, [1] parity error, [0] overrun
    typedef struct {
        logic [3:0] kind;
        logic [7:0] b;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         pending = 1'b0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    logic valid_prev = 1'b0;
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        logic [3:0] k;
        ev_t        e;
        k = {data_valid && (!valid_prev || ready_prev), frame_err, parity_err, overrun};
        if (k != 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual kind=%b byte=%h cyc=%0d required none",
                         k, data_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (k !== e.kind || cyc != e.at || (k[3] && data_out !== e.b)) begin
                    failures++;
                    $display("FAIL event actual kind=%b byte=%h cyc=%0d required kind=%b byte=%h cyc=%0d",
                             k, data_out, cyc, e.kind, e.b, e.at);
                end
            end
        end
        valid_prev = data_valid;
        ready_prev = ready;
    end

    task automatic wait_bit();
        repeat (N) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 so frames can abut with zero idle.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                              input int idle_bits);
        ev_t e;
        bit  pe;
        pe     = (PB == 1) && par_flip;
        e.b    = b;
        e.at   = cyc + 3 + H + (9 + PB) * N;
        e.kind = 4'b0;
        if (!stop_ok) e.kind[2] = 1'b1;
        if (pe) e.kind[1] = 1'b1;
        if (stop_ok && !pe) begin
            if (pending && !ready) begin
                e.kind[0] = 1'b1;
            end else begin
                e.kind[3] = 1'b1;
                last_good = b;
                pending   = !ready;
            end
        end
        if (e.kind != 4'b0) exp_q.push_back(e);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
        if (PB == 1) begin
            rx = (^b) ^ par_flip;
            wait_bit();
        end
        rx = stop_ok;
        wait_bit();
        rx = 1'b1;
        repeat (idle_bits) wait_bit();
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         idle;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        rst = 1'b0;
        repeat (2 * N) @(posedge clk);
        #1;

        send_frame(8'hEE, 1'b1, 1'b0, 1);
        check("ee_data_out", data_out, 8'hEE);
        check("ee_valid_dropped", data_valid, 1'b0);

        ready = 1'b0;
        send_frame(8'h55, 1'b1, 1'b0, 0);
        send_frame(8'hA3, 1'b1, 1'b0, 1);
        check("overrun_held_data", data_out, 8'h55);
        check("overrun_held_valid", data_valid, 1'b1);
        ready   = 1'b1;
        pending = 1'b0;
        wait_bit();
        check("accept_valid_low", data_valid, 1'b0);
        check("accept_data_kept", data_out, 8'h55);

        send_frame(8'h3C, 1'b0, 1'b0, 2);
        check("frame_err_data_out", data_out, last_good);
        check("frame_err_valid", data_valid, 1'b0);

        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        wait_bit();
        wait_bit();
        check("glitch_valid", data_valid, 1'b0);

        // Reset lands in bit 4 of a frame whose upper nibble is zero.
        b  = {4'h0, 4'($urandom_range(15))};
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_bit();
        end
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midframe_reset_data_out", data_out, 8'h00);
        check("midframe_reset_valid", data_valid, 1'b0);
        rst       = 1'b0;
        last_good = 8'h00;
        pending   = 1'b0;
        repeat (N - 7) @(posedge clk);
        #1;
        for (int i = 5; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
        rx = 1'b1;
        wait_bit();
        wait_bit();
        wait_bit();
        send_frame(8'h81, 1'b1, 1'b0, 1);
        check("after_reset_data_out", data_out, 8'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1);
        check("parity_ok_data", data_out, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1);
        check("parity_bad_valid", data_valid, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom);
            ok   = $urandom_range(7) != 0;
            idle = ok ? int'($urandom_range(2)) : 2;
            send_frame(b, ok, $urandom_range(4) == 0, idle);
        end

        for (int i = 0; i < 4 * N && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
